// File: rtl/bcd_bin_conv.sv
// Four-digit BCD to 16-bit binary converter using reverse double dabble
// (shift right, then subtract 3 from every nibble >= 8), with START/BUSY/DONE handshake.
module bcd_bin_conv (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [3:0]  MIL,
    input  logic [3:0]  CENT,
    input  logic [3:0]  DEC,
    input  logic [3:0]  UNIT,
    output logic [15:0] RESULT,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_ADJ,
        S_FIN
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_d;
    logic [15:0] r_b;
    logic [4:0]  r_cnt;
    logic [15:0] r_result;
    logic        r_err;
    logic        w_bad_digit;
    logic [15:0] w_d_adj;

    assign w_bad_digit = (MIL > 4'd9) | (CENT > 4'd9) | (DEC > 4'd9) | (UNIT > 4'd9);

    // Nibbles are corrected independently; no borrow crosses a digit boundary.
    always_comb begin
        w_d_adj = r_d;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_d[4*i +: 4] >= 4'd8)
                w_d_adj[4*i +: 4] = r_d[4*i +: 4] - 4'd3;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        BUSY   = 1'b1;
        DONE   = 1'b0;
        case (r_state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (START)
                    w_next = w_bad_digit ? S_FIN : S_SHIFT;
            end
            S_SHIFT: w_next = S_ADJ;
            S_ADJ:   w_next = (r_cnt == 5'd0) ? S_FIN : S_SHIFT;
            S_FIN: begin
                DONE   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_d      <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_d   <= {MIL, CENT, DEC, UNIT};
                        r_b   <= '0;
                        r_cnt <= 5'd16;
                        r_err <= w_bad_digit;
                    end
                end
                S_SHIFT: begin
                    {r_d, r_b} <= {1'b0, r_d, r_b[15:1]};
                    r_cnt      <= r_cnt - 5'd1;
                end
                S_ADJ: begin
                    r_d <= w_d_adj;
                    if (r_cnt == 5'd0)
                        r_result <= r_b;
                end
                default: ;
            endcase
        end
    end

    assign RESULT = r_result;
    assign ERR    = r_err;

endmodule

// File: tb/tb_bcd_bin_conv.sv
// Self-checking bench for bcd_bin_conv: directed handshake/timing cases plus
// randomized digit sets checked against an arithmetic decimal model.
module tb_bcd_bin_conv;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [3:0]  MIL, CENT, DEC, UNIT;
    logic [15:0] RESULT;
    logic        BUSY, DONE, ERR;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_result = 16'h0000;

    bcd_bin_conv dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .MIL    (MIL),
        .CENT   (CENT),
        .DEC    (DEC),
        .UNIT   (UNIT),
        .RESULT (RESULT),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .ERR    (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_value(input int m, input int c, input int d, input int u);
        return 16'(m * 1000 + c * 100 + d * 10 + u);
    endfunction

    // Drives digits and a one-cycle START; returns at the negedge just after the capture edge.
    task automatic do_start(input logic [3:0] m, input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
        @(negedge CLK);
        MIL = m; CENT = c; DEC = d; UNIT = u;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Called at cycle 0 after capture; optionally disturbs START/digits at cycle 'disturb'.
    task automatic wait_done(input int exp_lat, input int disturb, input logic [15:0] exp_res, input logic exp_err);
        int k = 0;
        int busy_n = 0;
        while (DONE !== 1'b1 && k < 40) begin
            if (BUSY === 1'b1) busy_n++;
            @(negedge CLK);
            k++;
            if (k == disturb) begin
                START = 1'b1;
                MIL = 4'($urandom_range(0, 9)); CENT = 4'($urandom_range(0, 9));
                DEC = 4'($urandom_range(0, 9)); UNIT = 4'($urandom_range(0, 9));
            end else if (k == disturb + 1) begin
                START = 1'b0;
            end
        end
        if (BUSY === 1'b1) busy_n++;
        chk("done_latency", k, exp_lat);
        chk("result", RESULT, exp_res);
        chk("err", ERR, exp_err);
        chk("busy_cycles", busy_n, exp_lat + 1);
        @(negedge CLK);
        chk("done_single", DONE, 1'b0);
        chk("busy_fall", BUSY, 1'b0);
        chk("err_held", ERR, exp_err);
        chk("result_held", RESULT, exp_res);
    endtask

    initial begin
        RST = 1'b1; START = 1'b0;
        MIL = 4'd0; CENT = 4'd0; DEC = 4'd0; UNIT = 4'd0;
        repeat (3) @(negedge CLK);
        chk("rst_result", RESULT, 16'h0000);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_err", ERR, 1'b0);
        RST = 1'b0;

        do_start(4'd0, 4'd0, 4'd0, 4'd0);
        chk("busy_after_start", BUSY, 1'b1);
        wait_done(32, -1, 16'h0000, 1'b0);

        do_start(4'd1, 4'd2, 4'd3, 4'd4);
        wait_done(32, -1, 16'h04D2, 1'b0);
        do_start(4'd9, 4'd9, 4'd9, 4'd9);
        wait_done(32, -1, 16'h270F, 1'b0);
        do_start(4'd0, 4'd0, 4'd0, 4'd8);
        wait_done(32, -1, 16'h0008, 1'b0);

        // Invalid digit: immediate DONE with ERR, previous RESULT kept
        do_start(4'd0, 4'd0, 4'd0, 4'd5);
        wait_done(32, -1, 16'h0005, 1'b0);
        do_start(4'd0, 4'hA, 4'd0, 4'd0);
        wait_done(0, -1, 16'h0005, 1'b1);

        // START and digit changes mid-conversion are ignored; ERR clears on next accepted START
        do_start(4'd1, 4'd2, 4'd3, 4'd4);
        chk("err_cleared", ERR, 1'b0);
        wait_done(32, 10, 16'h04D2, 1'b0);
        repeat (3) begin
            @(negedge CLK);
            chk("no_extra_done", DONE, 1'b0);
        end

        // START held through FIN is taken only from IDLE
        @(negedge CLK);
        MIL = 4'd1; CENT = 4'd2; DEC = 4'd3; UNIT = 4'd4;
        START = 1'b1;
        @(negedge CLK);
        wait_done(32, -1, 16'h04D2, 1'b0);
        MIL = 4'd0; CENT = 4'd0; DEC = 4'd4; UNIT = 4'd2;
        @(negedge CLK);
        START = 1'b0;
        chk("held_start_accepted", BUSY, 1'b1);
        wait_done(32, -1, 16'h002A, 1'b0);

        // Reset mid-conversion aborts without DONE and clears RESULT
        do_start(4'd9, 4'd8, 4'd7, 4'd6);
        repeat (15) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_result", RESULT, 16'h0000);
        chk("abort_done", DONE, 1'b0);
        RST = 1'b0;
        do_start(4'd0, 4'd0, 4'd4, 4'd2);
        wait_done(32, -1, 16'h002A, 1'b0);
        last_result = 16'h002A;

        for (int n = 0; n < 300; n++) begin
            int dg[4];
            bit bad;
            for (int j = 0; j < 4; j++) dg[j] = int'($urandom_range(0, 9));
            bad = ($urandom_range(0, 4) == 0);
            if (bad) dg[$urandom_range(0, 3)] = int'($urandom_range(10, 15));
            do_start(4'(dg[0]), 4'(dg[1]), 4'(dg[2]), 4'(dg[3]));
            if (bad) begin
                wait_done(0, -1, last_result, 1'b1);
            end else begin
                last_result = ref_value(dg[0], dg[1], dg[2], dg[3]);
                wait_done(32, -1, last_result, 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
